control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 53 +++++
 rtl/control_unit_decoder.sv | 86 ++++++++
 rtl/control_unit.sv | 115 +++++++++++
 tb/tb_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multi-cycle control unit:
// FSM states, instruction-field constants, datapath mux selects and the output bundle.
package control_unit_pkg;

  typedef enum logic [3:0] {
    RST, DECODE, ALU_EX, MEM_ADDR, ST_DATA, MEM_WAIT, LD_WB, BRANCH, NEXT
  } state_t;

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;
  localparam logic [2:0] OP2_BICC = 3'b010;

  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_PASS_B = 6'b000010;

  localparam logic [2:0] EXT_SIMM13 = 3'd0;
  localparam logic [2:0] EXT_DISP22 = 3'd1;
  localparam logic [2:0] EXT_DISP30 = 3'd2;
  localparam logic [2:0] EXT_IMM22  = 3'd3;

  localparam logic [1:0] PCIN_NPC    = 2'd0;
  localparam logic [1:0] PCIN_DISP22 = 2'd1;
  localparam logic [1:0] PCIN_DISP30 = 2'd2;

  localparam logic [2:0] ALUB_PB  = 3'd0;
  localparam logic [2:0] ALUB_EXT = 3'd1;
  localparam logic [2:0] ALUB_MDR = 3'd2;

  localparam logic MDR_PB  = 1'b0;
  localparam logic MDR_RAM = 1'b1;

  typedef struct packed {
    logic       pc_en, npc_en, mdr_en, mar_en, rf_en, ram_en, psr_en, tbr_en;
    logic [2:0] ext_sel;
    logic [1:0] pc_in_sel;
    logic [1:0] alua_sel;
    logic [2:0] alub_sel;
    logic [1:0] psr_sel;
    logic       mdr_sel;
    logic       tbr_sel;
    logic [4:0] in_pc, in_pa, in_pb;
    logic [5:0] alu_op;
    logic [5:0] ram_op;
    logic       tbr_clr, psr_clr;
  } ctrl_t;

  // op3[2] distinguishes stores from loads in the memory format
  function automatic logic is_store(input logic [5:0] op3);
    return op3[2];
  endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational output decode: maps the current FSM state and instruction
// word onto every datapath strobe and select.
module control_decoder
  import control_unit_pkg::*;
(
  input  state_t      state,
  input  logic [31:0] ir,
  input  logic        cond,
  input  logic        ba,
  input  logic        bn,
  output ctrl_t       ctrl
);

  logic [4:0] rd, rs1, rs2;
  logic [5:0] op3;
  logic       imm;
  logic       unused_ir;

  assign rd  = ir[29:25];
  assign op3 = ir[24:19];
  assign rs1 = ir[18:14];
  assign imm = ir[13];
  assign rs2 = ir[4:0];
  assign unused_ir = ^{ir[31:30], ir[12:5]};

  always_comb begin
    ctrl         = '0;
    ctrl.in_pa   = rs1;
    ctrl.in_pb   = rs2;
    ctrl.in_pc   = rd;
    ctrl.alu_op  = op3;
    ctrl.tbr_clr = 1'b1;
    ctrl.psr_clr = 1'b1;
    case (state)
      RST: begin
        ctrl.tbr_clr = 1'b0;
        ctrl.psr_clr = 1'b0;
      end
      ALU_EX: begin
        ctrl.rf_en    = 1'b1;
        ctrl.alub_sel = imm ? ALUB_EXT : ALUB_PB;
        ctrl.ext_sel  = EXT_SIMM13;
        ctrl.psr_en   = op3[4];
      end
      MEM_ADDR: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.alub_sel = imm ? ALUB_EXT : ALUB_PB;
        ctrl.mar_en   = 1'b1;
      end
      ST_DATA: begin
        // store data comes from rd through port B
        ctrl.in_pb   = rd;
        ctrl.mdr_sel = MDR_PB;
        ctrl.mdr_en  = 1'b1;
      end
      MEM_WAIT: begin
        ctrl.ram_en = 1'b1;
        ctrl.ram_op = op3;
        if (!is_store(op3)) begin
          ctrl.mdr_sel = MDR_RAM;
          ctrl.mdr_en  = 1'b1;
        end
      end
      LD_WB: begin
        ctrl.alub_sel = ALUB_MDR;
        ctrl.alu_op   = ALU_PASS_B;
        ctrl.rf_en    = 1'b1;
      end
      BRANCH: begin
        ctrl.pc_en  = 1'b1;
        ctrl.npc_en = 1'b1;
        if (ba | (cond & ~bn)) begin
          ctrl.ext_sel   = EXT_DISP22;
          ctrl.pc_in_sel = PCIN_DISP22;
        end
      end
      NEXT: begin
        ctrl.pc_en     = 1'b1;
        ctrl.npc_en    = 1'b1;
        ctrl.pc_in_sel = PCIN_NPC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: state register and sequencing live here,
// output decode is delegated to control_decoder.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] IR_Out,
  input  logic        MFC,
  input  logic        MSET,
  input  logic        cond,
  input  logic        BA_O,
  input  logic        BN_O,
  output logic        PC_enable,
  output logic        NPC_enable,
  output logic        MDR_Enable,
  output logic        MAR_Enable,
  output logic        register_file_enable,
  output logic        RAM_enable,
  output logic        PSR_Enable,
  output logic        TBR_enable,
  output logic [2:0]  extender_select,
  output logic [1:0]  PC_In_Mux_select,
  output logic [1:0]  ALUA_Mux_select,
  output logic [2:0]  ALUB_Mux_select,
  output logic [1:0]  PSR_Mux_select,
  output logic        MDR_Mux_select,
  output logic        TBR_Mux_select,
  output logic [4:0]  in_PC,
  output logic [4:0]  in_PA,
  output logic [4:0]  in_PB,
  output logic [5:0]  ALU_op,
  output logic [5:0]  RAM_OpCode,
  output logic [2:0]  tt,
  output logic        TBR_Clr,
  output logic        PSR_Clr,
  output logic        S,
  output logic        PS,
  output logic        ET
);

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   unused_mset;

  assign unused_mset = MSET;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state <= RST;
      S     <= 1'b1;
      PS    <= 1'b0;
      ET    <= 1'b0;
      tt    <= 3'b000;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RST:      state_nxt = DECODE;
      DECODE: begin
        case (IR_Out[31:30])
          OP_ALU:  state_nxt = ALU_EX;
          OP_MEM:  state_nxt = MEM_ADDR;
          OP_BR:   state_nxt = (IR_Out[24:22] == OP2_BICC) ? BRANCH : NEXT;
          default: state_nxt = NEXT;
        endcase
      end
      ALU_EX:   state_nxt = NEXT;
      MEM_ADDR: state_nxt = is_store(IR_Out[24:19]) ? ST_DATA : MEM_WAIT;
      ST_DATA:  state_nxt = MEM_WAIT;
      MEM_WAIT: if (MFC) state_nxt = is_store(IR_Out[24:19]) ? NEXT : LD_WB;
      LD_WB:    state_nxt = NEXT;
      BRANCH:   state_nxt = DECODE;
      NEXT:     state_nxt = DECODE;
      default:  state_nxt = RST;
    endcase
  end

  control_decoder u_dec (
    .state (state),
    .ir    (IR_Out),
    .cond  (cond),
    .ba    (BA_O),
    .bn    (BN_O),
    .ctrl  (ctrl)
  );

  assign PC_enable            = ctrl.pc_en;
  assign NPC_enable           = ctrl.npc_en;
  assign MDR_Enable           = ctrl.mdr_en;
  assign MAR_Enable           = ctrl.mar_en;
  assign register_file_enable = ctrl.rf_en;
  assign RAM_enable           = ctrl.ram_en;
  assign PSR_Enable           = ctrl.psr_en;
  assign TBR_enable           = ctrl.tbr_en;
  assign extender_select      = ctrl.ext_sel;
  assign PC_In_Mux_select     = ctrl.pc_in_sel;
  assign ALUA_Mux_select      = ctrl.alua_sel;
  assign ALUB_Mux_select      = ctrl.alub_sel;
  assign PSR_Mux_select       = ctrl.psr_sel;
  assign MDR_Mux_select       = ctrl.mdr_sel;
  assign TBR_Mux_select       = ctrl.tbr_sel;
  assign in_PC                = ctrl.in_pc;
  assign in_PA                = ctrl.in_pa;
  assign in_PB                = ctrl.in_pb;
  assign ALU_op               = ctrl.alu_op;
  assign RAM_OpCode           = ctrl.ram_op;
  assign TBR_Clr              = ctrl.tbr_clr;
  assign PSR_Clr              = ctrl.psr_clr;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        Clk, RESET, MFC, MSET, cond, BA_O, BN_O;
  logic [31:0] IR_Out;
  logic        PC_enable, NPC_enable, MDR_Enable, MAR_Enable, register_file_enable;
  logic        RAM_enable, PSR_Enable, TBR_enable, MDR_Mux_select, TBR_Mux_select;
  logic [2:0]  extender_select, ALUB_Mux_select, tt;
  logic [1:0]  PC_In_Mux_select, ALUA_Mux_select, PSR_Mux_select;
  logic [4:0]  in_PC, in_PA, in_PB;
  logic [5:0]  ALU_op, RAM_OpCode;
  logic        TBR_Clr, PSR_Clr, S, PS, ET;

  control_unit dut (
    .Clk(Clk), .RESET(RESET), .IR_Out(IR_Out), .MFC(MFC), .MSET(MSET), .cond(cond),
    .BA_O(BA_O), .BN_O(BN_O), .PC_enable(PC_enable), .NPC_enable(NPC_enable),
    .MDR_Enable(MDR_Enable), .MAR_Enable(MAR_Enable),
    .register_file_enable(register_file_enable), .RAM_enable(RAM_enable),
    .PSR_Enable(PSR_Enable), .TBR_enable(TBR_enable), .extender_select(extender_select),
    .PC_In_Mux_select(PC_In_Mux_select), .ALUA_Mux_select(ALUA_Mux_select),
    .ALUB_Mux_select(ALUB_Mux_select), .PSR_Mux_select(PSR_Mux_select),
    .MDR_Mux_select(MDR_Mux_select), .TBR_Mux_select(TBR_Mux_select),
    .in_PC(in_PC), .in_PA(in_PA), .in_PB(in_PB), .ALU_op(ALU_op), .RAM_OpCode(RAM_OpCode),
    .tt(tt), .TBR_Clr(TBR_Clr), .PSR_Clr(PSR_Clr), .S(S), .PS(PS), .ET(ET)
  );

  localparam int B_PC = 7, B_NPC = 6, B_MDR = 5, B_MAR = 4, B_RF = 3, B_RAM = 2, B_PSR = 1;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] strb;   // pc npc mdr mar rf ram psr tbr
    logic [2:0] ext;
    logic [1:0] pcin;
    logic [2:0] alub;
    logic       mdrs;
    logic [4:0] zsel;   // ALUA, PSR mux, TBR mux: always 0
    logic [4:0] pc, pa, pb;
    logic [5:0] aluop, ramop;
    logic [1:0] clr;    // TBR_Clr, PSR_Clr
    logic [5:0] sys;    // S PS ET tt
  } obs_t;

  obs_t  expq[$];
  string nameq[$];
  int    total = 0;
  int    bad = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: the DUT presents a control word every cycle.
  always @(negedge Clk) begin
    obs_t got, e;
    string n;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n = nameq.pop_front();
      got.st    = dut.state;
      got.strb  = {PC_enable, NPC_enable, MDR_Enable, MAR_Enable, register_file_enable,
                   RAM_enable, PSR_Enable, TBR_enable};
      got.ext   = extender_select;
      got.pcin  = PC_In_Mux_select;
      got.alub  = ALUB_Mux_select;
      got.mdrs  = MDR_Mux_select;
      got.zsel  = {ALUA_Mux_select, PSR_Mux_select, TBR_Mux_select};
      got.pc    = in_PC;
      got.pa    = in_PA;
      got.pb    = in_PB;
      got.aluop = ALU_op;
      got.ramop = RAM_OpCode;
      got.clr   = {TBR_Clr, PSR_Clr};
      got.sys   = {S, PS, ET, tt};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got %h required %h", n, got, e);
      end
    end
  end

  function automatic obs_t mk(state_t s, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [5:0] op3);
    obs_t e = '0;
    e.st = s; e.pc = rd; e.pa = rs1; e.pb = rs2; e.aluop = op3;
    e.clr = 2'b11; e.sys = 6'b100000;
    return e;
  endfunction

  task automatic push(string n, obs_t e);
    expq.push_back(e);
    nameq.push_back(n);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic alu_instr(string n, logic [31:0] ir, logic [4:0] rd, logic [4:0] rs1,
                           logic [4:0] rs2, logic [5:0] op3, logic i);
    obs_t e;
    IR_Out = ir;
    push({n, "_dec"}, mk(DECODE, rd, rs1, rs2, op3));
    tick();
    e = mk(ALU_EX, rd, rs1, rs2, op3);
    e.strb[B_RF] = 1'b1; e.alub = {2'b00, i}; e.strb[B_PSR] = op3[4];
    push({n, "_ex"}, e);
    tick();
    e = mk(NEXT, rd, rs1, rs2, op3);
    e.strb[B_PC] = 1'b1; e.strb[B_NPC] = 1'b1;
    push({n, "_next"}, e);
    tick();
  endtask

  task automatic mem_instr(string n, logic [31:0] ir, logic [4:0] rd, logic [4:0] rs1,
                           logic [4:0] rs2, logic [5:0] op3, logic i, logic store,
                           int nwait, logic rst_in_wait);
    obs_t e;
    IR_Out = ir;
    push({n, "_dec"}, mk(DECODE, rd, rs1, rs2, op3));
    tick();
    e = mk(MEM_ADDR, rd, rs1, rs2, op3);
    e.aluop = 6'b000000; e.alub = {2'b00, i}; e.strb[B_MAR] = 1'b1;
    push({n, "_addr"}, e);
    tick();
    if (store) begin
      e = mk(ST_DATA, rd, rs1, rd, op3);
      e.strb[B_MDR] = 1'b1;
      push({n, "_stdata"}, e);
      tick();
    end
    for (int k = 0; k < nwait; k++) begin
      e = mk(MEM_WAIT, rd, rs1, rs2, op3);
      e.strb[B_RAM] = 1'b1; e.ramop = op3;
      if (!store) begin e.mdrs = 1'b1; e.strb[B_MDR] = 1'b1; end
      push({n, "_wait"}, e);
      MFC = (k == nwait - 1) && !rst_in_wait;
      RESET = rst_in_wait && (k == nwait - 1);
      tick();
    end
    MFC = 1'b0;
    if (rst_in_wait) begin
      e = mk(RST, rd, rs1, rs2, op3);
      e.clr = 2'b00;
      push({n, "_rst"}, e);
      RESET = 1'b0;
      tick();
      return;
    end
    if (!store) begin
      e = mk(LD_WB, rd, rs1, rs2, op3);
      e.alub = 3'd2; e.aluop = 6'b000010; e.strb[B_RF] = 1'b1;
      push({n, "_wb"}, e);
      tick();
    end
    e = mk(NEXT, rd, rs1, rs2, op3);
    e.strb[B_PC] = 1'b1; e.strb[B_NPC] = 1'b1;
    push({n, "_next"}, e);
    tick();
  endtask

  task automatic br_instr(string n, logic [31:0] ir, logic [4:0] rd, logic [4:0] rs1,
                          logic [4:0] rs2, logic [5:0] op3, logic c, logic ba, logic bn,
                          logic taken);
    obs_t e;
    IR_Out = ir; cond = c; BA_O = ba; BN_O = bn;
    push({n, "_dec"}, mk(DECODE, rd, rs1, rs2, op3));
    tick();
    e = mk(BRANCH, rd, rs1, rs2, op3);
    e.strb[B_PC] = 1'b1; e.strb[B_NPC] = 1'b1;
    if (taken) begin e.ext = 3'd1; e.pcin = 2'd1; end
    push({n, "_br"}, e);
    tick();
  endtask

  task automatic other_instr(string n, logic [31:0] ir, logic [4:0] rd, logic [4:0] rs1,
                             logic [4:0] rs2, logic [5:0] op3);
    obs_t e;
    IR_Out = ir;
    push({n, "_dec"}, mk(DECODE, rd, rs1, rs2, op3));
    tick();
    e = mk(NEXT, rd, rs1, rs2, op3);
    e.strb[B_PC] = 1'b1; e.strb[B_NPC] = 1'b1;
    push({n, "_next"}, e);
    tick();
  endtask

  initial begin
    obs_t e;
    RESET = 1'b1; IR_Out = 32'h0; MFC = 1'b0; MSET = 1'b0;
    cond = 1'b0; BA_O = 1'b0; BN_O = 1'b0;
    tick();
    e = mk(RST, 5'd0, 5'd0, 5'd0, 6'd0);
    e.clr = 2'b00;
    push("reset", e);
    RESET = 1'b0;
    tick();

    alu_instr("add_imm", 32'h82002003, 5'd1, 5'd0, 5'd3, 6'h00, 1'b1);
    alu_instr("add_reg", 32'h84004002, 5'd2, 5'd1, 5'd2, 6'h00, 1'b0);
    alu_instr("addcc",   32'h82804002, 5'd1, 5'd1, 5'd2, 6'h10, 1'b0);
    alu_instr("add_r0",  32'h80006005, 5'd0, 5'd1, 5'd5, 6'h00, 1'b1);
    mem_instr("st", 32'hC4202020, 5'd2, 5'd0, 5'd0, 6'h04, 1'b1, 1'b1, 3, 1'b0);
    mem_instr("ld", 32'hC6002020, 5'd3, 5'd0, 5'd0, 6'h00, 1'b1, 1'b0, 2, 1'b0);
    br_instr("ba",       32'h02800004, 5'd1, 5'd0, 5'd4, 6'h10, 1'b0, 1'b1, 1'b0, 1'b1);
    br_instr("bn",       32'h02800004, 5'd1, 5'd0, 5'd4, 6'h10, 1'b1, 1'b0, 1'b1, 1'b0);
    br_instr("bcc_t",    32'h02800004, 5'd1, 5'd0, 5'd4, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    br_instr("bcc_nt",   32'h02800004, 5'd1, 5'd0, 5'd4, 6'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    cond = 1'b0; BA_O = 1'b0; BN_O = 1'b0;
    other_instr("sethi", 32'h03000001, 5'd1, 5'd0, 5'd1, 6'h20);
    other_instr("call",  32'h40000001, 5'd0, 5'd0, 5'd1, 6'h00);
    mem_instr("ld_rst", 32'hC6002020, 5'd3, 5'd0, 5'd0, 6'h00, 1'b1, 1'b0, 1, 1'b1);
    alu_instr("add_after_rst", 32'h82002003, 5'd1, 5'd0, 5'd3, 6'h00, 1'b1);

    tick();
    tick();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, required 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
